// File: rtl/id_dispatch_ctrl_if.sv
// Handshake bundle between the ID stage, the dispatch controller and ROB allocation.
// Transfer rule for both channels: a beat moves on a rising clock edge where
// valid and ready are both high. id_ready never looks at id_valid, and rob_valid
// never looks at rob_ready. A payload is only meaningful while its valid is high.
interface id_dispatch_ctrl_if #(
  parameter int PAYLOAD_W = 128
) ();
  logic                 id_valid;
  logic                 id_ready;
  logic [PAYLOAD_W-1:0] id_payload;
  logic                 id_br_undet;
  logic                 id_serialize;
  logic                 rob_valid;
  logic                 rob_ready;
  logic [PAYLOAD_W-1:0] rob_payload;
  logic                 rob_empty;
  logic                 br_resolve;
  logic                 serial_commit;

  // Environment side: ID producer plus ROB consumer and commit feedback.
  modport master (
    output id_valid, id_payload, id_br_undet, id_serialize,
    output rob_ready, rob_empty, br_resolve, serial_commit,
    input  id_ready, rob_valid, rob_payload
  );

  // Dispatch controller side.
  modport slave (
    input  id_valid, id_payload, id_br_undet, id_serialize,
    input  rob_ready, rob_empty, br_resolve, serial_commit,
    output id_ready, rob_valid, rob_payload
  );
endinterface

// File: rtl/id_dispatch_ctrl.sv
// Dispatch controller between ID and ROB allocation: a small in-order queue,
// an undetermined-branch limiter and a serializer for CP0-write/ERET-class ops.
// fsm_state exposes the serializer state (0=RUN, 1=DRAIN, 2=WAIT).
module id_dispatch_ctrl #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 128,
  parameter int MAX_BR    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  id_dispatch_ctrl_if.slave        bus,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [2:0]               br_inflight,
  output logic [1:0]               fsm_state
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [AW:0]          wptr, rptr;
  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     ser_mem;
  logic                 full, empty, br_full, head_ser;
  logic                 push, pop, rob_valid_c;
  logic                 br_inc, br_dec;

  // The wrap bit separates full from empty when the indices match.
  assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign empty    = (wptr == rptr);
  assign br_full  = (br_inflight == 3'(MAX_BR));
  assign head_ser = ser_mem[rptr[AW-1:0]];

  // A full queue refuses even on a popping cycle; no combinational pass-through.
  assign bus.id_ready    = rst & ~flush & ~full & ~(bus.id_br_undet & br_full);
  assign push            = bus.id_valid & bus.id_ready;
  assign pop             = rob_valid_c & bus.rob_ready;
  assign bus.rob_valid   = rob_valid_c;
  assign bus.rob_payload = empty ? '0 : mem[rptr[AW-1:0]];
  assign queue_count     = wptr - rptr;
  assign fsm_state       = state;

  assign br_inc = push & bus.id_br_undet;
  assign br_dec = bus.br_resolve & (br_inflight != 3'd0);

  // Serializer next state and the dispatch offer to the ROB.
  always_comb begin
    state_nxt   = state;
    rob_valid_c = 1'b0;
    if (flush) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!empty) begin
            if (head_ser) state_nxt   = DRAIN;
            else          rob_valid_c = 1'b1;
          end
        end
        DRAIN: begin
          // The serializing head goes out only into an empty ROB.
          rob_valid_c = bus.rob_empty & ~empty;
          if (rob_valid_c && bus.rob_ready) state_nxt = WAIT;
        end
        WAIT: begin
          if (bus.serial_commit) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Queue pointers; flush empties the queue in one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Entry storage: payload plus the serialize flag; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]]     <= bus.id_payload;
      ser_mem[wptr[AW-1:0]] <= bus.id_serialize;
    end
  end

  // Undetermined-branch counter: queued plus dispatched, not yet resolved.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_inflight <= 3'd0;
    end else if (flush) begin
      br_inflight <= 3'd0;
    end else if (br_inc && !br_dec) begin
      br_inflight <= br_inflight + 3'd1;
    end else if (br_dec && !br_inc) begin
      br_inflight <= br_inflight - 3'd1;
    end
  end
endmodule

// File: tb/tb_id_dispatch_ctrl.sv
// Bench for id_dispatch_ctrl: directed table, hand sequences and random traffic
// compared against a queue-based reference model.
module tb_id_dispatch_ctrl;
  localparam int DEPTH  = 4;
  localparam int PW     = 128;
  localparam int MAX_BR = 4;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] queue_count;
  logic [2:0] br_inflight;
  logic [1:0] fsm_state;

  id_dispatch_ctrl_if #(.PAYLOAD_W(PW)) bus ();

  id_dispatch_ctrl #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .MAX_BR(MAX_BR)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .queue_count (queue_count),
    .br_inflight (br_inflight),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: in-order list of entries, a branch tally, and two flags for
  // "serializing op is next and may leave once the ROB is empty" and
  // "serializing op has left, waiting for its commit".
  typedef struct {
    logic [PW-1:0] pl;
    bit            ser;
  } ent_t;
  ent_t m_q[$];
  int   m_br;
  bit   m_armed, m_wait;
  bit   m_ir, m_rv;

  task automatic model_clear();
    m_q.delete();
    m_br = 0; m_armed = 0; m_wait = 0;
  endtask

  task automatic model_check();
    logic [PW-1:0] exp_pl;
    int            exp_st;
    m_ir = !flush && (m_q.size() < DEPTH) && !(bus.id_br_undet && m_br == MAX_BR);
    if (flush || m_wait)  m_rv = 0;
    else if (m_armed)     m_rv = bus.rob_empty && (m_q.size() > 0);
    else                  m_rv = (m_q.size() > 0) && !m_q[0].ser;
    exp_pl = (m_q.size() > 0) ? m_q[0].pl : '0;
    exp_st = m_wait ? 2 : (m_armed ? 1 : 0);
    chk("m_id_ready",    PW'(bus.id_ready),    PW'(m_ir));
    chk("m_rob_valid",   PW'(bus.rob_valid),   PW'(m_rv));
    chk("m_rob_payload", bus.rob_payload,      exp_pl);
    chk("m_queue_count", PW'(queue_count),     PW'(m_q.size()));
    chk("m_br_inflight", PW'(br_inflight),     PW'(m_br));
    chk("m_fsm_state",   PW'(fsm_state),       PW'(exp_st));
  endtask

  task automatic model_update();
    bit   push, pop, head_ser;
    ent_t e;
    if (flush) begin
      model_clear();
      return;
    end
    push     = bus.id_valid && m_ir;
    pop      = m_rv && bus.rob_ready;
    head_ser = (m_q.size() > 0) && m_q[0].ser;
    if (m_wait) begin
      if (bus.serial_commit) m_wait = 0;
    end else if (m_armed) begin
      if (pop) begin m_armed = 0; m_wait = 1; end
    end else if (head_ser) begin
      m_armed = 1;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.pl = bus.id_payload; e.ser = bus.id_serialize;
      m_q.push_back(e);
    end
    m_br = m_br + ((push && bus.id_br_undet) ? 1 : 0) - ((bus.br_resolve && m_br > 0) ? 1 : 0);
  endtask

  // Called 2 time units after inputs change at a falling edge.
  task automatic tick();
    model_check();
    model_update();
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input bit fl, input bit v, input bit bu, input bit se,
                       input logic [PW-1:0] pl, input bit rr, input bit re,
                       input bit brr, input bit sc);
    flush             = fl;
    bus.id_valid      = v;
    bus.id_br_undet   = bu;
    bus.id_serialize  = se;
    bus.id_payload    = pl;
    bus.rob_ready     = rr;
    bus.rob_empty     = re;
    bus.br_resolve    = brr;
    bus.serial_commit = sc;
  endtask

  task automatic idle(input bit rr, input bit re);
    drive(0, 0, 0, 0, '0, rr, re, 0, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit       v, bu, rr, brr;
    logic [7:0] pl;
    bit       e_ir, e_rv;
    logic [7:0] e_pl;
    int       e_cnt, e_br;
  } vec_t;
  vec_t vt[$];

  task automatic add(input bit v, input bit bu, input logic [7:0] pl, input bit rr,
                     input bit brr, input bit e_ir, input bit e_rv,
                     input logic [7:0] e_pl, input int e_cnt, input int e_br);
    vec_t r;
    r.v = v; r.bu = bu; r.pl = pl; r.rr = rr; r.brr = brr;
    r.e_ir = e_ir; r.e_rv = e_rv; r.e_pl = e_pl; r.e_cnt = e_cnt; r.e_br = e_br;
    vt.push_back(r);
  endtask

  initial begin
    logic [PW-1:0] rp;
    // backpressure: 4 accepted, 5th held until the cycle after the first pop
    add(1,0,8'h01,0,0, 1,0,8'h00,0,0);
    add(1,0,8'h02,0,0, 1,1,8'h01,1,0);
    add(1,0,8'h03,0,0, 1,1,8'h01,2,0);
    add(1,0,8'h04,0,0, 1,1,8'h01,3,0);
    add(1,0,8'h05,0,0, 0,1,8'h01,4,0);
    add(1,0,8'h05,1,0, 0,1,8'h01,4,0);
    add(1,0,8'h05,1,0, 1,1,8'h02,3,0);
    add(0,0,8'h00,1,0, 1,1,8'h03,3,0);
    add(0,0,8'h00,1,0, 1,1,8'h04,2,0);
    add(0,0,8'h00,1,0, 1,1,8'h05,1,0);
    add(0,0,8'h00,1,0, 1,0,8'h00,0,0);
    // branch limit
    add(1,1,8'h11,1,0, 1,0,8'h00,0,0);
    add(1,1,8'h12,1,0, 1,1,8'h11,1,1);
    add(1,1,8'h13,1,0, 1,1,8'h12,1,2);
    add(1,1,8'h14,1,0, 1,1,8'h13,1,3);
    add(1,1,8'h15,1,0, 0,1,8'h14,1,4);
    add(1,0,8'h16,1,0, 1,0,8'h00,0,4);
    add(1,1,8'h17,1,1, 0,1,8'h16,1,4);
    add(1,1,8'h17,1,0, 1,0,8'h00,0,3);
    add(0,0,8'h00,1,1, 1,1,8'h17,1,4);
    add(1,1,8'h18,1,1, 1,0,8'h00,0,3);
    add(0,0,8'h00,1,0, 1,1,8'h18,1,3);
    add(0,0,8'h00,1,0, 1,0,8'h00,0,3);

    model_clear();
    rst = 1'b0;
    idle(0, 1);
    @(negedge clk);
    #2;
    chk("rst_id_ready",    PW'(bus.id_ready),  '0);
    chk("rst_rob_valid",   PW'(bus.rob_valid), '0);
    chk("rst_rob_payload", bus.rob_payload,    '0);
    chk("rst_queue_count", PW'(queue_count),   '0);
    chk("rst_br_inflight", PW'(br_inflight),   '0);
    chk("rst_fsm_state",   PW'(fsm_state),     '0);
    @(negedge clk);
    rst = 1'b1;

    // streaming 0x1..0x8 with the ROB always ready
    for (int i = 0; i <= 9; i++) begin
      if (i < 8) drive(0, 1, 0, 0, PW'(i + 1), 1, 1, 0, 0);
      else       idle(1, 1);
      #2;
      chk("stream_rob_valid", PW'(bus.rob_valid), PW'(i >= 1 && i <= 8));
      if (i >= 1 && i <= 8) chk("stream_payload", bus.rob_payload, PW'(i));
      chk("stream_count_le1", PW'(queue_count <= 1), PW'(1));
      tick();
    end

    // directed table
    foreach (vt[k]) begin
      drive(0, vt[k].v, vt[k].bu, 0, PW'(vt[k].pl), vt[k].rr, 1, vt[k].brr, 0);
      #2;
      chk($sformatf("tab%0d_id_ready", k),    PW'(bus.id_ready),  PW'(vt[k].e_ir));
      chk($sformatf("tab%0d_rob_valid", k),   PW'(bus.rob_valid), PW'(vt[k].e_rv));
      chk($sformatf("tab%0d_rob_payload", k), bus.rob_payload,    PW'(vt[k].e_pl));
      chk($sformatf("tab%0d_count", k),       PW'(queue_count),   PW'(vt[k].e_cnt));
      chk($sformatf("tab%0d_br", k),          PW'(br_inflight),   PW'(vt[k].e_br));
      tick();
    end

    // serialization: 0xA normal, 0xB serialize, 0xC normal
    drive(0, 1, 0, 0, PW'(8'hA), 1, 0, 0, 0); #2;
    chk("ser0_rob_valid", PW'(bus.rob_valid), '0); tick();
    drive(0, 1, 0, 1, PW'(8'hB), 1, 0, 0, 0); #2;
    chk("ser1_rob_valid", PW'(bus.rob_valid), PW'(1));
    chk("ser1_payload",   bus.rob_payload,    PW'(8'hA)); tick();
    drive(0, 1, 0, 0, PW'(8'hC), 1, 0, 0, 0); #2;
    chk("ser2_rob_valid", PW'(bus.rob_valid), '0);
    chk("ser2_state",     PW'(fsm_state),     '0); tick();
    idle(1, 0); #2;
    chk("ser3_state",     PW'(fsm_state),     PW'(1));
    chk("ser3_rob_valid", PW'(bus.rob_valid), '0); tick();
    idle(1, 1); #2;
    chk("ser4_rob_valid", PW'(bus.rob_valid), PW'(1));
    chk("ser4_payload",   bus.rob_payload,    PW'(8'hB)); tick();
    idle(1, 1); #2;
    chk("ser5_state",     PW'(fsm_state),     PW'(2));
    chk("ser5_rob_valid", PW'(bus.rob_valid), '0);
    chk("ser5_payload",   bus.rob_payload,    PW'(8'hC)); tick();
    drive(0, 0, 0, 0, '0, 1, 1, 0, 1); #2;
    chk("ser6_rob_valid", PW'(bus.rob_valid), '0); tick();
    idle(1, 1); #2;
    chk("ser7_state",     PW'(fsm_state),     '0);
    chk("ser7_rob_valid", PW'(bus.rob_valid), PW'(1));
    chk("ser7_payload",   bus.rob_payload,    PW'(8'hC)); tick();
    idle(1, 1); #2; tick();

    // clear leftover branch count, then build the flush scenario
    drive(1, 0, 0, 0, '0, 1, 1, 0, 0); #2; tick();
    drive(0, 1, 0, 1, PW'(8'h20), 1, 1, 0, 0); #2; tick();
    drive(0, 1, 1, 0, PW'(8'h21), 1, 1, 0, 0); #2; tick();
    drive(0, 1, 1, 0, PW'(8'h22), 1, 1, 0, 0); #2; tick();
    drive(0, 1, 0, 0, PW'(8'h23), 1, 1, 0, 0); #2; tick();
    drive(1, 1, 0, 0, PW'(8'h24), 1, 1, 0, 0); #2;
    chk("fl_pre_count",  PW'(queue_count),   PW'(3));
    chk("fl_pre_br",     PW'(br_inflight),   PW'(2));
    chk("fl_pre_state",  PW'(fsm_state),     PW'(2));
    chk("fl_rob_valid",  PW'(bus.rob_valid), '0);
    chk("fl_id_ready",   PW'(bus.id_ready),  '0); tick();
    idle(1, 1); #2;
    chk("fl_post_count", PW'(queue_count),   '0);
    chk("fl_post_br",    PW'(br_inflight),   '0);
    chk("fl_post_state", PW'(fsm_state),     '0);
    chk("fl_post_valid", PW'(bus.rob_valid), '0); tick();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, rp,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      #2;
      tick();
    end

    // asynchronous reset in the middle of a transfer
    drive(1, 0, 0, 0, '0, 0, 1, 0, 0); #2; tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, PW'(8'h40 + i), 0, 1, 0, 0); #2; tick();
    end
    drive(0, 1, 0, 0, PW'(8'h50), 1, 1, 0, 0); #2;
    rst = 1'b0;
    #1;
    chk("arst_rob_valid",   PW'(bus.rob_valid), '0);
    chk("arst_rob_payload", bus.rob_payload,    '0);
    chk("arst_count",       PW'(queue_count),   '0);
    chk("arst_br",          PW'(br_inflight),   '0);
    chk("arst_id_ready",    PW'(bus.id_ready),  '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    drive(0, 1, 0, 0, PW'(8'h77), 1, 1, 0, 0); #2;
    chk("post_rst_id_ready", PW'(bus.id_ready), PW'(1)); tick();
    idle(1, 1); #2;
    chk("post_rst_valid",   PW'(bus.rob_valid), PW'(1));
    chk("post_rst_payload", bus.rob_payload,    PW'(8'h77)); tick();
    idle(1, 1); #2; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
